// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared types and constants for the AES cipher-text serializer slice.
//   byte_t      : one state byte
//   state_t     : 4x4 AES state, indexed [row][col]
//   AES_WORD_W  : width of one serialized column word
//   ser_state_e : serializer FSM states
// -----------------------------------------------------------------------------
package aes_pkg;

    typedef logic [7:0] byte_t;
    typedef byte_t [3:0][3:0] state_t;

    localparam int AES_WORD_W = 32;

    typedef enum logic [0:0] {
        SER_IDLE,
        SER_SEND
    } ser_state_e;

endpackage

// File: rtl/aes_blk_fifo.sv
// -----------------------------------------------------------------------------
// aes_blk_fifo
// BUF_DEPTH-entry storage of complete AES state matrices.
// Ports:
//   clk_i, rst_ni : clock (rising edge), asynchronous active-low reset
//   push_i        : write wdata_i at the write pointer
//   pop_i         : retire the entry at the read pointer
//   wdata_i       : block to store
//   rdata_o       : block at the read pointer
//   count_o       : number of stored blocks (0..BUF_DEPTH)
//   full_o        : count_o == BUF_DEPTH
//   empty_o       : count_o == 0
// A push while full is accepted only when a pop happens in the same cycle;
// otherwise it is ignored and the caller is expected to flag the drop.
// -----------------------------------------------------------------------------
module aes_blk_fifo
    import aes_pkg::*;
#(
    parameter int BUF_DEPTH = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  state_t                     wdata_i,
    output state_t                     rdata_o,
    output logic [$clog2(BUF_DEPTH):0] count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    state_t             mem_q [BUF_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               push_ok;
    logic               pop_ok;

    assign full_o  = (count_q == CNT_W'(BUF_DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // A full buffer can still take a block when one leaves on the same edge.
    assign push_ok = push_i & (~full_o | pop_i);
    assign pop_ok  = pop_i & ~empty_o;

    // Pointers wrap naturally because BUF_DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
        count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; contents are only observed while non-empty.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/aes_ct_serializer.sv
// -----------------------------------------------------------------------------
// aes_ct_serializer
// Captures each completed cipher-text matrix from aes_en_core on the rising
// edge of cipher_text_rdy_i, buffers up to BUF_DEPTH blocks and drains each
// one as four 32-bit column words over a valid/ready stream.
// Ports:
//   aes_clk, resetn     : clock (rising edge), asynchronous active-low reset
//   cipher_text_rdy_i   : block valid level from the core
//   cipher_text_i       : 4x4 cipher-text matrix, [row][col]
//   ct_word_o           : column word {m[0][c], m[1][c], m[2][c], m[3][c]}
//   ct_word_vld_o       : ct_word_o valid
//   ct_word_rdy_i       : consumer ready
//   ct_last_o           : current word is column 3 of its block
//   ct_ovf_o            : sticky, a block was dropped on a full buffer
//   ct_ovf_clr_i        : clears ct_ovf_o (wins over a same-cycle drop)
//   busy_o              : buffer non-empty
// Optional (macro AES_CT_SER_STATS_EN):
//   ct_blk_cnt_o        : drained blocks, wraps at 16 bits
//   ct_drop_cnt_o       : dropped blocks, saturates at 0xFF
//
// state    | meaning
// ---------+--------------------------------------------------------------
// SER_IDLE | nothing to send, vld low; leaves once the buffer holds a block
// SER_SEND | presenting column col_q of the oldest block, vld high
// -----------------------------------------------------------------------------
module aes_ct_serializer
    import aes_pkg::*;
#(
    parameter int NO_ROWS   = 4,
    parameter int NO_COLS   = 4,
    parameter int BUF_DEPTH = 2
) (
    input  logic                  aes_clk,
    input  logic                  resetn,
    input  logic                  cipher_text_rdy_i,
    input  state_t                cipher_text_i,
    output logic [AES_WORD_W-1:0] ct_word_o,
    output logic                  ct_word_vld_o,
    input  logic                  ct_word_rdy_i,
    output logic                  ct_last_o,
    output logic                  ct_ovf_o,
    input  logic                  ct_ovf_clr_i,
`ifdef AES_CT_SER_STATS_EN
    output logic [15:0]           ct_blk_cnt_o,
    output logic [7:0]            ct_drop_cnt_o,
`endif
    output logic                  busy_o
);

    localparam int          CNT_W    = $clog2(BUF_DEPTH) + 1;
    localparam int          COL_W    = $clog2(NO_COLS);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(NO_COLS - 1);

    ser_state_e         state_q, state_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic               rdy_q;
    logic               ovf_q, ovf_d;

    logic               capture_stb;
    logic               send;
    logic               hs;
    logic               blk_done;
    logic               drop;

    state_t             fifo_rdata;
    logic [CNT_W-1:0]   fifo_cnt;
    logic               fifo_full;
    logic               fifo_empty;
    logic [AES_WORD_W-1:0] col_word;

    // A level held high for many cycles yields a single capture.
    assign capture_stb = cipher_text_rdy_i & ~rdy_q;

    assign send     = (state_q == SER_SEND);
    assign hs       = send & ct_word_rdy_i;
    assign blk_done = hs & (col_q == LAST_COL);
    // Final-word handshake frees a slot on the same edge, so no drop then.
    assign drop     = capture_stb & fifo_full & ~blk_done;

    aes_blk_fifo #(
        .BUF_DEPTH (BUF_DEPTH)
    ) u_blk_fifo (
        .clk_i   (aes_clk),
        .rst_ni  (resetn),
        .push_i  (capture_stb),
        .pop_i   (blk_done),
        .wdata_i (cipher_text_i),
        .rdata_o (fifo_rdata),
        .count_o (fifo_cnt),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Row 0 lands in the most significant byte.
    always_comb begin
        col_word = '0;
        for (int r = 0; r < NO_ROWS; r++) begin
            col_word[AES_WORD_W-1-8*r -: 8] = fifo_rdata[2'(r)][col_q];
        end
    end

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        case (state_q)
            SER_IDLE: begin
                col_d = '0;
                if (!fifo_empty) begin
                    state_d = SER_SEND;
                end
            end
            SER_SEND: begin
                if (hs) begin
                    col_d = col_q + COL_W'(1);
                end
                if (blk_done) begin
                    col_d = '0;
                    // Stay in SEND for back-to-back blocks; a capture on this
                    // edge is always accepted, so it also keeps us busy.
                    if ((fifo_cnt == CNT_W'(1)) && !capture_stb) begin
                        state_d = SER_IDLE;
                    end
                end
            end
            default: begin
                state_d = SER_IDLE;
                col_d   = '0;
            end
        endcase
    end

    always_comb begin
        ovf_d = ovf_q;
        if (ct_ovf_clr_i) begin
            ovf_d = 1'b0;
        end else if (drop) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge aes_clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= SER_IDLE;
            col_q   <= '0;
            rdy_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            rdy_q   <= cipher_text_rdy_i;
            ovf_q   <= ovf_d;
        end
    end

    assign ct_word_vld_o = send;
    assign ct_last_o     = send & (col_q == LAST_COL);
    assign ct_word_o     = send ? col_word : '0;
    assign ct_ovf_o      = ovf_q;
    assign busy_o        = ~fifo_empty;

`ifdef AES_CT_SER_STATS_EN
    logic [15:0] blk_cnt_q, blk_cnt_d;
    logic [7:0]  drop_cnt_q, drop_cnt_d;

    always_comb begin
        blk_cnt_d  = blk_cnt_q + 16'(blk_done);
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge aes_clk or negedge resetn) begin
        if (!resetn) begin
            blk_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            blk_cnt_q  <= blk_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign ct_blk_cnt_o  = blk_cnt_q;
    assign ct_drop_cnt_o = drop_cnt_q;
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_aes_ct_serializer.sv
module tb_aes_ct_serializer;
    import aes_pkg::*;

    localparam int DEPTH = 2;

    logic        aes_clk = 1'b0;
    logic        resetn = 1'b0;
    logic        cipher_text_rdy_i = 1'b0;
    state_t      cipher_text_i;
    logic [31:0] ct_word_o;
    logic        ct_word_vld_o;
    logic        ct_word_rdy_i = 1'b0;
    logic        ct_last_o;
    logic        ct_ovf_o;
    logic        ct_ovf_clr_i = 1'b0;
    logic        busy_o;
`ifdef AES_CT_SER_STATS_EN
    logic [15:0] ct_blk_cnt_o;
    logic [7:0]  ct_drop_cnt_o;
`endif

    aes_ct_serializer #(.NO_ROWS(4), .NO_COLS(4), .BUF_DEPTH(DEPTH)) dut (
        .aes_clk           (aes_clk),
        .resetn            (resetn),
        .cipher_text_rdy_i (cipher_text_rdy_i),
        .cipher_text_i     (cipher_text_i),
        .ct_word_o         (ct_word_o),
        .ct_word_vld_o     (ct_word_vld_o),
        .ct_word_rdy_i     (ct_word_rdy_i),
        .ct_last_o         (ct_last_o),
        .ct_ovf_o          (ct_ovf_o),
        .ct_ovf_clr_i      (ct_ovf_clr_i),
`ifdef AES_CT_SER_STATS_EN
        .ct_blk_cnt_o      (ct_blk_cnt_o),
        .ct_drop_cnt_o     (ct_drop_cnt_o),
`endif
        .busy_o            (busy_o)
    );

    always #5 aes_clk = ~aes_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_checks = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Reference model: a queue of buffered blocks, the column being shown,
    // and the valid / overflow flags, updated once per clock.
    state_t      m_q[$];
    int          m_col;
    bit          m_vld;
    bit          m_ovf;
    bit          m_prev;
    logic [15:0] m_blk;
    logic [7:0]  m_drop;

    logic [31:0] dut_words[$];
    int          vld_cycles;

    function automatic logic [31:0] m_word(input state_t m, input int c);
        logic [31:0] w;
        w = 32'h0;
        for (int r = 0; r < 4; r++) w = (w << 8) | 32'(m[2'(r)][2'(c)]);
        return w;
    endfunction

    function automatic state_t rand_blk();
        state_t b;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                b[2'(r)][2'(c)] = 8'($urandom_range(0, 255));
        return b;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_col = 0;
        m_vld = 0;
        m_ovf = 0;
        m_prev = 0;
        m_blk = '0;
        m_drop = '0;
    endtask

    task automatic model_step();
        bit hs, done, cap, dropped;
        int n_before;
        hs = m_vld && ct_word_rdy_i;
        done = hs && (m_col == 3);
        cap = cipher_text_rdy_i && !m_prev;
        n_before = m_q.size();
        dropped = 0;
        if (hs) m_col = (m_col + 1) % 4;
        if (done) begin
            void'(m_q.pop_front());
            m_blk = m_blk + 16'd1;
        end
        if (cap) begin
            if (n_before < DEPTH || done) m_q.push_back(cipher_text_i);
            else dropped = 1;
        end
        if (dropped && m_drop != 8'hFF) m_drop = m_drop + 8'd1;
        if (ct_ovf_clr_i) m_ovf = 0;
        else if (dropped) m_ovf = 1;
        m_vld = m_vld ? (m_q.size() != 0) : (n_before != 0);
        m_prev = cipher_text_rdy_i;
    endtask

    task automatic check_outputs();
        logic [31:0] ew;
        ew = (m_vld && m_q.size() != 0) ? m_word(m_q[0], m_col) : 32'h0;
        chk("vld", 32'(ct_word_vld_o), 32'(m_vld));
        chk("word", ct_word_o, ew);
        chk("last", 32'(ct_last_o), 32'(m_vld && m_col == 3));
        chk("busy", 32'(busy_o), 32'(m_q.size() != 0));
        chk("ovf", 32'(ct_ovf_o), 32'(m_ovf));
`ifdef AES_CT_SER_STATS_EN
        chk("blk_cnt", 32'(ct_blk_cnt_o), 32'(m_blk));
        chk("drop_cnt", 32'(ct_drop_cnt_o), 32'(m_drop));
`endif
    endtask

    // Called at a falling edge: check, drive, advance the model, next falling edge.
    task automatic cycle(input bit rdy, input state_t ct, input bit wrdy, input bit clr);
        check_outputs();
        cipher_text_rdy_i = rdy;
        cipher_text_i = ct;
        ct_word_rdy_i = wrdy;
        ct_ovf_clr_i = clr;
        if (ct_word_vld_o && wrdy) dut_words.push_back(ct_word_o);
        if (ct_word_vld_o) vld_cycles++;
        model_step();
        @(posedge aes_clk);
        @(negedge aes_clk);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        cipher_text_rdy_i = 1'b0;
        ct_word_rdy_i = 1'b0;
        ct_ovf_clr_i = 1'b0;
        model_reset();
        @(negedge aes_clk);
        @(negedge aes_clk);
        resetn = 1'b1;
    endtask

    task automatic chk_block_words(input string name, input int base, input state_t b);
        for (int c = 0; c < 4; c++) begin
            if (dut_words.size() > base + c) chk(name, dut_words[base + c], m_word(b, c));
            else chk({name, "_missing"}, 32'hdead_dead, m_word(b, c));
        end
    endtask

    typedef struct {
        logic        rdy;
        logic        vld;
        logic [31:0] word;
        logic        last;
        logic        busy;
    } vec_t;

    vec_t        tab[7];
    logic [7:0]  fips_b[16];
    state_t      fips;
    state_t      zero_blk;
    state_t      b1, b2, b3, b4;
    bit          ph, collided;

    initial begin
        fips_b = '{8'h39, 8'h25, 8'h84, 8'h1d, 8'h02, 8'hdc, 8'h09, 8'hfb,
                   8'hdc, 8'h11, 8'h85, 8'h97, 8'h19, 8'h6a, 8'h0b, 8'h32};
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                fips[2'(r)][2'(c)] = fips_b[c * 4 + r];
        zero_blk = '0;
        cipher_text_i = '0;

        tab[0] = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b0};
        tab[1] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1};
        tab[2] = '{1'b0, 1'b1, 32'h3925841d, 1'b0, 1'b1};
        tab[3] = '{1'b0, 1'b1, 32'h02dc09fb, 1'b0, 1'b1};
        tab[4] = '{1'b0, 1'b1, 32'hdc118597, 1'b0, 1'b1};
        tab[5] = '{1'b0, 1'b1, 32'h196a0b32, 1'b1, 1'b1};
        tab[6] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0};

        // Reset state
        model_reset();
        @(negedge aes_clk);
        @(negedge aes_clk);
        chk("rst_vld", 32'(ct_word_vld_o), 32'h0);
        chk("rst_word", ct_word_o, 32'h0);
        chk("rst_last", 32'(ct_last_o), 32'h0);
        chk("rst_ovf", 32'(ct_ovf_o), 32'h0);
        chk("rst_busy", 32'(busy_o), 32'h0);
        resetn = 1'b1;
        @(negedge aes_clk);

        // FIPS-197 vector, table driven
        for (int i = 0; i < 7; i++) begin
            chk("fips_vld", 32'(ct_word_vld_o), 32'(tab[i].vld));
            chk("fips_word", ct_word_o, tab[i].word);
            chk("fips_last", 32'(ct_last_o), 32'(tab[i].last));
            chk("fips_busy", 32'(busy_o), 32'(tab[i].busy));
            cycle(tab[i].rdy, tab[i].rdy ? fips : zero_blk, 1'b1, 1'b0);
        end

        // Backpressure: ready alternates 0/1 while valid is high
        b1 = rand_blk();
        dut_words.delete();
        vld_cycles = 0;
        ph = 0;
        cycle(1'b1, b1, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            if (ct_word_vld_o) begin
                cycle(1'b0, zero_blk, ph, 1'b0);
                ph = ~ph;
            end else begin
                cycle(1'b0, zero_blk, 1'b0, 1'b0);
            end
        end
        chk("bp_cycles", 32'(vld_cycles), 32'd8);
        chk_block_words("bp_word", 0, b1);

        // Level held high for 10 cycles: one block only
        b2 = rand_blk();
        dut_words.delete();
        for (int i = 0; i < 10; i++) cycle(1'b1, b2, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) cycle(1'b0, zero_blk, 1'b1, 1'b0);
        chk("lvl_count", 32'(dut_words.size()), 32'd4);
        chk_block_words("lvl_word", 0, b2);

        // Overflow with three captures while the consumer is stalled
        do_reset();
        b1 = rand_blk(); b2 = rand_blk(); b3 = rand_blk();
        cycle(1'b1, b1, 1'b0, 1'b0);
        cycle(1'b0, zero_blk, 1'b0, 1'b0);
        cycle(1'b1, b2, 1'b0, 1'b0);
        cycle(1'b0, zero_blk, 1'b0, 1'b0);
        cycle(1'b1, b3, 1'b0, 1'b0);
        cycle(1'b0, zero_blk, 1'b0, 1'b0);
        chk("ovf_set", 32'(ct_ovf_o), 32'h1);
        dut_words.delete();
        for (int i = 0; i < 8; i++) cycle(1'b0, zero_blk, 1'b1, 1'b0);
        chk("ovf_drain_n", 32'(dut_words.size()), 32'd8);
        chk("ovf_drain_busy", 32'(busy_o), 32'h0);
        chk_block_words("ovf_blk1", 0, b1);
        chk_block_words("ovf_blk2", 4, b2);
        chk("ovf_still_set", 32'(ct_ovf_o), 32'h1);
        cycle(1'b0, zero_blk, 1'b0, 1'b1);
        chk("ovf_clr", 32'(ct_ovf_o), 32'h0);
`ifdef AES_CT_SER_STATS_EN
        chk("ovf_drop_cnt", 32'(ct_drop_cnt_o), 32'd1);
        chk("ovf_blk_cnt", 32'(ct_blk_cnt_o), 32'd2);
`endif

        // Full buffer, capture on the column-3 handshake cycle
        do_reset();
        b1 = rand_blk(); b2 = rand_blk(); b3 = rand_blk(); b4 = rand_blk();
        cycle(1'b1, b1, 1'b0, 1'b0);
        cycle(1'b0, zero_blk, 1'b0, 1'b0);
        cycle(1'b1, b2, 1'b0, 1'b0);
        cycle(1'b0, zero_blk, 1'b0, 1'b0);
        collided = 0;
        for (int i = 0; i < 10 && !collided; i++) begin
            if (m_vld && m_col == 3) begin
                cycle(1'b1, b3, 1'b1, 1'b0);
                collided = 1;
            end else begin
                cycle(1'b0, zero_blk, 1'b1, 1'b0);
            end
        end
        chk("col_reached", 32'(collided), 32'h1);
        dut_words.delete();
        chk("col_no_ovf", 32'(ct_ovf_o), 32'h0);
        chk("col_busy", 32'(busy_o), 32'h1);
        // Buffer must still be full: a further capture is dropped.
        cycle(1'b0, zero_blk, 1'b0, 1'b0);
        cycle(1'b1, b4, 1'b0, 1'b0);
        cycle(1'b0, zero_blk, 1'b0, 1'b0);
        chk("col_full_after", 32'(ct_ovf_o), 32'h1);
        cycle(1'b0, zero_blk, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) cycle(1'b0, zero_blk, 1'b1, 1'b0);
        chk("col_drain_n", 32'(dut_words.size()), 32'd8);
        chk_block_words("col_blk2", 0, b2);
        chk_block_words("col_blk3", 4, b3);
        chk("col_idle", 32'(busy_o), 32'h0);

        // Asynchronous reset after the second word of a block
        do_reset();
        b1 = rand_blk(); b2 = rand_blk(); b3 = rand_blk();
        cycle(1'b1, b1, 1'b0, 1'b0);
        cycle(1'b0, zero_blk, 1'b0, 1'b0);
        cycle(1'b1, b2, 1'b0, 1'b0);
        cycle(1'b0, zero_blk, 1'b0, 1'b0);
        cycle(1'b1, b3, 1'b0, 1'b0);
        cycle(1'b0, zero_blk, 1'b0, 1'b0);
        cycle(1'b0, zero_blk, 1'b1, 1'b0);
        cycle(1'b0, zero_blk, 1'b1, 1'b0);
        chk("mid_pre_vld", 32'(ct_word_vld_o), 32'h1);
        chk("mid_pre_ovf", 32'(ct_ovf_o), 32'h1);
        #2;
        resetn = 1'b0;
        #1;
        chk("mid_rst_vld", 32'(ct_word_vld_o), 32'h0);
        chk("mid_rst_last", 32'(ct_last_o), 32'h0);
        chk("mid_rst_busy", 32'(busy_o), 32'h0);
        chk("mid_rst_ovf", 32'(ct_ovf_o), 32'h0);
        model_reset();
        @(negedge aes_clk);
        resetn = 1'b1;
        dut_words.delete();
        vld_cycles = 0;
        for (int i = 0; i < 10; i++) cycle(1'b0, zero_blk, 1'b1, 1'b0);
        chk("mid_after_words", 32'(dut_words.size()), 32'd0);
        chk("mid_after_vld", 32'(vld_cycles), 32'd0);

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            cycle($urandom_range(0, 2) == 0, rand_blk(), $urandom_range(0, 2) != 0,
                  $urandom_range(0, 19) == 0);
        end
        for (int i = 0; i < 20; i++) cycle(1'b0, zero_blk, 1'b1, 1'b0);
        chk("rand_idle", 32'(busy_o), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_ct_serializer.md
Name: aes_ct_serializer

Overview:
Downstream stage of aes_en_core. Captures each completed 4x4 cipher_text matrix when cipher_text_rdy rises and buffers up to BUF_DEPTH blocks. Drains each block as four 32-bit column words over a valid/ready stream toward the host/bus interface, so the core never waits on the consumer.

Parameters:
NO_ROWS, 4, state rows; only 4 supported
NO_COLS, 4, state columns; only 4 supported
BUF_DEPTH, 2, block buffer entries; power of 2, >= 2

Ports:
aes_clk  input  1  clock, rising edge
resetn  input  1  asynchronous active-low reset
cipher_text_rdy_i  input  1  from aes_en_core cipher_text_rdy_o; block valid while high
cipher_text_i  input  8 x [3:0][3:0]  from aes_en_core cipher_text_o; index [row][col]
ct_word_o  output  32  current column word
ct_word_vld_o  output  1  ct_word_o valid
ct_word_rdy_i  input  1  consumer ready
ct_last_o  output  1  high with column 3 of a block
ct_ovf_o  output  1  sticky: a block was dropped because the buffer was full
ct_ovf_clr_i  input  1  clears ct_ovf_o
busy_o  output  1  buffer non-empty

Behaviour:
- Clocking and reset: one clock aes_clk; reset is asynchronous and active-low on resetn. All outputs reset to 0. Buffer pointers, counters, FSM and edge register also reset; rdy_q resets to 0.
- Capture: registered rdy_q; capture strobe = cipher_text_rdy_i & ~rdy_q. A level held high for N cycles gives exactly one capture. Matrix is written into the buffer entry at wr_ptr on the strobe cycle.
- Full: strobe while count == BUF_DEPTH and no block is completing this cycle -> block dropped, ct_ovf_o = 1 next cycle, buffer unchanged.
- Simultaneous capture and final-word handshake (col 3 accepted) while full: the capture is accepted, there is no overflow, and count is unchanged.
- Word format: word for column c = {m[0][c], m[1][c], m[2][c], m[3][c]}, row 0 in bits 31:24. Columns are sent in order 0,1,2,3.
- FSM IDLE: vld = 0. Go to SEND when count != 0. Entry is one cycle after the capture, so first-word latency from the capture edge is 1 cycle.
- FSM SEND: vld = 1, ct_word_o = column col_cnt of the entry at rd_ptr.
  - On vld & rdy: col_cnt++.
  - When col_cnt == 3 and the handshake occurs: col_cnt -> 0, rd_ptr++, count--, ct_last_o deasserts. If the buffer is still non-empty, stay in SEND (back-to-back blocks, no bubble); otherwise go to IDLE.
- Stream rules: while vld is high and rdy is low, ct_word_o, ct_last_o and vld are held stable. vld never drops without a handshake.
- ct_last_o = SEND & (col_cnt == 3).
- Pointers wrap modulo BUF_DEPTH. count is $clog2(BUF_DEPTH)+1 bits wide.
- ct_ovf_clr_i has priority over a same-cycle set: the flag is cleared, and the drop is still lost.
- busy_o = (count != 0).
- resetn asserted mid-block: the block in flight and all buffered blocks are discarded. vld falls asynchronously.

Optional Feature:
Macro AES_CT_SER_STATS_EN.
- Defined: adds two ports.
  - ct_blk_cnt_o output 16: counts completed drained blocks, wraps at 0xFFFF -> 0.
  - ct_drop_cnt_o output 8: counts dropped blocks, saturates at 0xFF.
  - Both reset to 0 and are not cleared by ct_ovf_clr_i.
- Undefined: these ports and their counters do not exist, and behaviour is otherwise identical.

Decomposition:
- Package aes_pkg holds:
  - typedef byte_t (logic [7:0])
  - typedef state_t (byte_t [3:0][3:0])
  - AES_WORD_W = 32
  - FSM enum ser_state_e {SER_IDLE, SER_SEND}
- One sub-module, aes_blk_fifo: BUF_DEPTH-entry state_t storage with wr/rd pointers, count, full and empty. It takes simultaneous push/pop and allows push when full if a pop happens in the same cycle. Column mux and FSM stay in the top.

Test Plan:
1. FIPS-197 vector: drive cipher_text_i = 39 25 84 1d 02 dc 09 fb dc 11 85 97 19 6a 0b 32 (column-major), rdy pulse 1 cycle, ct_word_rdy_i = 1 -> words 0x3925841d, 0x02dc09fb, 0xdc118597, 0x196a0b32 on 4 consecutive cycles starting 1 cycle after capture; ct_last_o only on the 4th word; busy_o back to 0 after it.
2. Backpressure: ct_word_rdy_i toggled 1/0 per cycle -> each word held stable until accepted, order unchanged, 8 cycles to drain.
3. Level hold: rdy held high 10 cycles -> exactly one block (4 words) emitted.
4. Overflow: ct_word_rdy_i = 0, three distinct blocks captured with BUF_DEPTH = 2 -> ct_ovf_o = 1; with rdy released, only blocks 1 and 2 come out (8 words, back-to-back, no bubble). Then ct_ovf_clr_i pulse -> ct_ovf_o = 0; with AES_CT_SER_STATS_EN, ct_drop_cnt_o = 1 and ct_blk_cnt_o = 2.
5. Full + final-word collision: buffer full and capture on the same cycle as the column-3 handshake -> no overflow, count stays 2, new block drained later.
6. Reset mid-block: resetn low after the 2nd word -> vld, last, busy and ovf go to 0 immediately. After release with no new capture, no words are emitted.
